axi4_lite_master_cmd: RTL and testbench

Synthesizable AXI4-Lite master command engine that converts single-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions and returns one response per command. It sits directly upstream of the AXI4-Lite slave BFM in the bench, and of any AXI4-Lite register slave in the design. It drives the bus the slave consumes. Data width is 32 bits, and exactly one transaction is in flight at a time.

---
 rtl/axi4_lite_master_cmd_if.sv | 64 ++++++
 rtl/axi4_lite_master_cmd.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi4_lite_master_cmd.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_cmd_if.sv
// Command/response port plus AXI4-Lite master bus for axi4_lite_master_cmd.
// Modports:
//   master - the command engine: accepts commands, returns responses and
//            drives the AW/W/AR channels plus BREADY/RREADY.
//   slave  - the environment: command source, response sink and AXI slave.
interface axi4_lite_master_cmd_if;
  // command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  // AXI4-Lite write address / data / response
  logic [31:0] m_awaddr;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  // AXI4-Lite read address / data
  logic [31:0] m_araddr;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, busy,
           m_awaddr, m_awcache, m_awprot, m_awvalid,
           m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arcache, m_arprot, m_arvalid, m_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, busy,
           m_awaddr, m_awcache, m_awprot, m_awvalid,
           m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arcache, m_arprot, m_arvalid, m_rready
  );
endinterface

// File: rtl/axi4_lite_master_cmd.sv
// AXI4-Lite master command engine: turns single-word read/write commands into
// one AXI4-Lite transaction at a time and returns one response per command.
// Ports:
//   aclk   - clock, rising edge
//   areset - asynchronous active-high reset
//   bus    - axi4_lite_master_cmd_if.master (command, response, AXI bus, busy)
// Parameters: TIMEOUT (watchdog limit, 2..65535), CACHE, PROT (AxCACHE/AxPROT).
// Optional feature: define AXI4_LITE_MASTER_CMD_TIMEOUT_EN to build a 16-bit
// watchdog that abandons a stalled bus transaction with rsp_resp = 2'b11.
module axi4_lite_master_cmd #(
  parameter int unsigned TIMEOUT = 256,
  parameter logic [3:0]  CACHE   = 4'b0000,
  parameter logic [2:0]  PROT    = 3'b000
) (
  input logic                    aclk,
  input logic                    areset,
  axi4_lite_master_cmd_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axi4_lite_master_cmd: TIMEOUT out of range 2..65535");
  end

  logic [2:0]  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          rsp_write_d = bus.cmd_write;
          if (bus.cmd_write) begin
            awaddr_d  = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently, in either order
        if (awvalid_q && bus.m_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && bus.m_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bus.m_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = bus.m_bresp;
          rsp_rdata_d = 32'd0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (bus.m_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = bus.m_rdata;
          rsp_resp_d  = bus.m_rresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
    // Watchdog overrides any bus progress; it knowingly drops valids mid-handshake
    if (state_q == ST_IDLE) begin
      wd_d = 16'd0;
    end else if (state_q != ST_RSP) begin
      wd_d = wd_q + 16'd1;
      if (wd_q == WD_LAST) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_resp_d  = 2'b11;
        rsp_rdata_d = 32'd0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_resp_q  <= 2'b00;
      awaddr_q    <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      araddr_q    <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
      wd_q        <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awcache = CACHE;
  assign bus.m_awprot  = PROT;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arcache = CACHE;
  assign bus.m_arprot  = PROT;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Directed bench for axi4_lite_master_cmd; expected values are hand-derived
// from the command timing (accept at edge N -> valids after N, rsp_valid after N+2).
module tb_axi4_lite_master_cmd;

  logic aclk;
  logic areset;
  int   n_vec;
  int   n_err;

  axi4_lite_master_cmd_if bus ();

  axi4_lite_master_cmd #(
    .TIMEOUT (16),
    .CACHE   (4'b0000),
    .PROT    (3'b000)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    areset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_wstrb = 4'd0;
    bus.rsp_ready = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bresp   = 2'b00;
    bus.m_bvalid  = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rdata   = 32'd0;
    bus.m_rresp   = 2'b00;
    bus.m_rvalid  = 1'b0;

    // Reset state
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_awvalid", 32'(bus.m_awvalid), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_resp", 32'(bus.rsp_resp), 32'd0);
    chk("rst_awaddr", bus.m_awaddr, 32'd0);
    areset = 1'b0;
    tick();
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Best-case write
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    bus.m_bvalid  = 1'b1;
    bus.m_bresp   = 2'b00;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0010;
    bus.cmd_wdata = 32'hDEAD_BEEF;
    bus.cmd_wstrb = 4'hF;
    tick();  // N: accept
    bus.cmd_valid = 1'b0;
    chk("w1_awvalid", 32'(bus.m_awvalid), 32'd1);
    chk("w1_wvalid", 32'(bus.m_wvalid), 32'd1);
    chk("w1_awaddr", bus.m_awaddr, 32'h0000_0010);
    chk("w1_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", 32'(bus.m_wstrb), 32'hF);
    chk("w1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("w1_busy", 32'(bus.busy), 32'd1);
    tick();  // N+1: AW/W handshake
    chk("w1_awvalid_drop", 32'(bus.m_awvalid), 32'd0);
    chk("w1_bready", 32'(bus.m_bready), 32'd1);
    chk("w1_rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();  // N+2: bvalid captured
    chk("w1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("w1_rsp_write", 32'(bus.rsp_write), 32'd1);
    chk("w1_rsp_resp", 32'(bus.rsp_resp), 32'd0);
    chk("w1_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("w1_bready_drop", 32'(bus.m_bready), 32'd0);
    bus.m_bvalid  = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();  // N+3: response handshake
    chk("w1_rsp_done", 32'(bus.rsp_valid), 32'd0);
    chk("w1_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("w1_idle_busy", 32'(bus.busy), 32'd0);
    bus.rsp_ready = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;

    // Read with 3 wait cycles on R
    bus.m_arready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0020;
    tick();
    bus.cmd_valid = 1'b0;
    chk("r1_arvalid", 32'(bus.m_arvalid), 32'd1);
    chk("r1_araddr", bus.m_araddr, 32'h0000_0020);
    chk("r1_awvalid", 32'(bus.m_awvalid), 32'd0);
    tick();
    chk("r1_arvalid_drop", 32'(bus.m_arvalid), 32'd0);
    chk("r1_rready", 32'(bus.m_rready), 32'd1);
    bus.m_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_wait_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h1234_5678;
    bus.m_rresp  = 2'b10;
    tick();
    bus.m_rvalid = 1'b0;
    chk("r1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("r1_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("r1_rsp_resp", 32'(bus.rsp_resp), 32'h2);
    chk("r1_rsp_write", 32'(bus.rsp_write), 32'd0);
    chk("r1_rready_drop", 32'(bus.m_rready), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("r1_rsp_done", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Write with W delayed 5 cycles, then response back-pressure
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b1;
    bus.m_bresp   = 2'b01;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0044;
    bus.cmd_wdata = 32'h0BAD_F00D;
    bus.cmd_wstrb = 4'h3;
    tick();  // N
    bus.cmd_valid = 1'b0;
    chk("w2_wvalid_n", 32'(bus.m_wvalid), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();  // N+1..N+5
      chk("w2_awvalid_low", 32'(bus.m_awvalid), 32'd0);
      chk("w2_wvalid_hold", 32'(bus.m_wvalid), 32'd1);
      chk("w2_bready_low", 32'(bus.m_bready), 32'd0);
    end
    bus.m_wready = 1'b1;
    tick();  // N+6: W handshake
    chk("w2_wvalid_drop", 32'(bus.m_wvalid), 32'd0);
    chk("w2_bready", 32'(bus.m_bready), 32'd1);
    tick();  // N+7: bresp captured
    chk("w2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("w2_rsp_resp", 32'(bus.rsp_resp), 32'h1);
    chk("w2_bready_once", 32'(bus.m_bready), 32'd0);
    // stray bvalid with new bresp and a second command while rsp_ready is low
    bus.m_bresp   = 2'b11;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0080;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_resp", 32'(bus.rsp_resp), 32'h1);
      chk("bp_rsp_write", 32'(bus.rsp_write), 32'd1);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_arvalid", 32'(bus.m_arvalid), 32'd0);
    end
    bus.m_bvalid  = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();  // M
    bus.rsp_ready = 1'b0;
    chk("bp_rsp_done", 32'(bus.rsp_valid), 32'd0);
    chk("bp_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("bp_not_yet", 32'(bus.m_arvalid), 32'd0);
    bus.m_arready = 1'b1;
    tick();  // M+1: second command accepted
    bus.cmd_valid = 1'b0;
    chk("c2_arvalid", 32'(bus.m_arvalid), 32'd1);
    chk("c2_araddr", bus.m_araddr, 32'h0000_0080);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hAABB_CCDD;
    bus.m_rresp  = 2'b00;
    tick();
    chk("c2_rready", 32'(bus.m_rready), 32'd1);
    tick();
    bus.m_rvalid  = 1'b0;
    bus.m_arready = 1'b0;
    chk("c2_rsp_rdata", bus.rsp_rdata, 32'hAABB_CCDD);
    chk("c2_rsp_write", 32'(bus.rsp_write), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;

    // Reset pulsed in WR_RESP
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0100;
    bus.cmd_wdata = 32'h5555_AAAA;
    bus.cmd_wstrb = 4'hF;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("rs_in_wr_resp", 32'(bus.m_bready), 32'd1);
    #1;
    areset = 1'b1;
    #1;
    chk("rs_bready", 32'(bus.m_bready), 32'd0);
    chk("rs_awaddr", bus.m_awaddr, 32'd0);
    chk("rs_wdata", bus.m_wdata, 32'd0);
    chk("rs_wstrb", 32'(bus.m_wstrb), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd0);
    chk("rs_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.m_bvalid = 1'b1;
    bus.m_bresp  = 2'b10;
    tick();
    areset = 1'b0;
    tick();
    chk("rs_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("rs_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rs_stray_bvalid", 32'(bus.rsp_valid), 32'd0);
    chk("rs_stray_bready", 32'(bus.m_bready), 32'd0);
    chk("rs_stray_busy", 32'(bus.busy), 32'd0);
    bus.m_bvalid  = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;

    // Read with AR never accepted
    bus.m_arready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0200;
    tick();  // N
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_arvalid_hold", 32'(bus.m_arvalid), 32'd1);
    end
    tick();  // N+16
`ifdef AXI4_LITE_MASTER_CMD_TIMEOUT_EN
    chk("to_arvalid_drop", 32'(bus.m_arvalid), 32'd0);
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_resp", 32'(bus.rsp_resp), 32'h3);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_idle", 32'(bus.busy), 32'd0);
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("nt_busy", 32'(bus.busy), 32'd1);
      chk("nt_arvalid", 32'(bus.m_arvalid), 32'd1);
      chk("nt_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
